// File: rtl/lenet_layer_seq.sv
// Layer sequencer for the LeNet accelerator: enables each engine in index order until it finishes,
// guards every stage with a watchdog, and reports done, error and the busy-cycle total.
module lenet_layer_seq #(
  parameter int NUM_STAGES = 5,
  parameter int IDX_W      = 3,
  parameter int TIMEOUT    = 1048576,
  parameter int TO_W       = 20,
  parameter int CNT_W      = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_STAGES-1:0] stage_finish,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [IDX_W-1:0]      stage_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [IDX_W-1:0]      err_stage,
  output logic [CNT_W-1:0]      total_cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_GAP,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);
  localparam logic [TO_W-1:0]  WD_LIMIT = TO_W'(TIMEOUT - 1);

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [TO_W-1:0]         wdog_q, wdog_d;
  logic [NUM_STAGES-1:0]   en_q, en_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic [IDX_W-1:0]        errStage_q, errStage_d;
  logic [CNT_W-1:0]        total_q, total_d;
  logic                    curFinish;

  assign curFinish = stage_finish[idx_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      wdog_q     <= '0;
      en_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      errStage_q <= '0;
      total_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wdog_q     <= wdog_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      errStage_q <= errStage_d;
      total_q    <= total_d;
    end
  end

  // Abort beats finish, and finish beats the watchdog, within a single RUN cycle.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wdog_d     = wdog_q;
    error_d    = error_q;
    errStage_d = errStage_q;
    total_d    = total_q;
    if (busy_q && (total_q != '1)) begin
      total_d = total_q + 1'b1;
    end

    case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          state_d = S_RUN;
          idx_d   = '0;
          wdog_d  = '0;
          error_d = 1'b0;
          total_d = '0;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (curFinish) begin
          state_d = (idx_q == LAST_IDX) ? S_DONE : S_GAP;
        end else if (wdog_q == WD_LIMIT) begin
          state_d    = S_ERR;
          error_d    = 1'b1;
          errStage_d = idx_q;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RUN;
          idx_d   = idx_q + 1'b1;
          wdog_d  = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    en_d   = '0;
    if (state_d == S_RUN) begin
      en_d = NUM_STAGES'(1) << idx_d;
    end
    busy_d = (state_d == S_RUN) || (state_d == S_GAP);
    done_d = (state_d == S_DONE);
  end

  assign stage_en     = en_q;
  assign stage_idx    = idx_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign err_stage    = errStage_q;
  assign total_cycles = total_q;

endmodule

// File: tb/tb_lenet_layer_seq.sv
// Scoreboard bench for lenet_layer_seq: each run pushes its expected outcome, and a negedge
// monitor measures enable lengths and pops/compares whenever a run ends.
module tb_lenet_layer_seq;

  localparam int NS = 2;
  localparam int IW = 1;
  localparam int TO = 8;
  localparam int TW = 3;
  localparam int CW = 8;

  localparam int K_DONE  = 0;
  localparam int K_ERR   = 1;
  localparam int K_ABORT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [NS-1:0] stage_finish;
  logic [NS-1:0] stage_en;
  logic [IW-1:0] stage_idx;
  logic          busy;
  logic          done;
  logic          error;
  logic [IW-1:0] err_stage;
  logic [CW-1:0] total_cycles;

  typedef struct {
    int kind;
    int en0;
    int en1;
    int gap;
    int total;
    int errStage;
    int err;
  } exp_t;

  exp_t expQ[$];
  int   vecCount  = 0;
  int   missCount = 0;
  int   len0, len1, gapLen;
  bit   prevBusy = 1'b0;
  bit   prevErr  = 1'b0;

  lenet_layer_seq #(
    .NUM_STAGES(NS), .IDX_W(IW), .TIMEOUT(TO), .TO_W(TW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .stage_finish(stage_finish),
    .stage_en(stage_en), .stage_idx(stage_idx), .busy(busy), .done(done), .error(error),
    .err_stage(err_stage), .total_cycles(total_cycles)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: measures the enable profile of a run and scores it when the run ends.
  always @(negedge clk) begin
    int   evt;
    exp_t e;
    if (!rst) begin
      prevBusy = 1'b0;
      prevErr  = 1'b0;
    end else begin
      if (busy && !prevBusy) begin
        len0 = 0; len1 = 0; gapLen = 0;
      end
      if (stage_en == 2'b01) len0++;
      else if (stage_en == 2'b10) len1++;
      else if (stage_en == 2'b00 && busy) gapLen++;
      checkOutput("enOneHot", 32'($countones(stage_en) <= 1), 1);

      evt = -1;
      if (done) evt = K_DONE;
      else if (error && !prevErr) evt = K_ERR;
      else if (prevBusy && !busy) evt = K_ABORT;

      if (evt >= 0) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedRunEnd", 32'(evt), 99);
        end else begin
          e = expQ.pop_front();
          checkOutput("endKind", 32'(evt), 32'(e.kind));
          checkOutput("en0Cycles", 32'(len0), 32'(e.en0));
          checkOutput("en1Cycles", 32'(len1), 32'(e.en1));
          checkOutput("gapCycles", 32'(gapLen), 32'(e.gap));
          checkOutput("totalCycles", 32'(total_cycles), 32'(e.total));
          checkOutput("errorFlag", 32'(error), 32'(e.err));
          checkOutput("busyAtEnd", 32'(busy), 0);
          if (e.kind == K_ERR) checkOutput("errStage", 32'(err_stage), 32'(e.errStage));
        end
      end
      prevBusy = busy;
      prevErr  = error;
    end
  end

  // One run: engines finish after finN enabled cycles (0 = never); optional abort/stray/restart.
  task automatic applyStimulus(input string name, input int fin0, input int fin1,
                               input int abortAt1, input bit stray, input bit restart,
                               input int eKind, input int eEn0, input int eEn1, input int eGap,
                               input int eTotal, input int eErrStage, input int eErr);
    exp_t e;
    int   c0 = 0;
    int   c1 = 0;
    int   iter = 0;
    e.kind = eKind; e.en0 = eEn0; e.en1 = eEn1; e.gap = eGap;
    e.total = eTotal; e.errStage = eErrStage; e.err = eErr;
    expQ.push_back(e);
    $display("[TB] run %s", name);

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput({name, ".startEn"}, 32'(stage_en), 1);
    checkOutput({name, ".startBusy"}, 32'(busy), 1);
    checkOutput({name, ".startErr"}, 32'(error), 0);
    checkOutput({name, ".startIdx"}, 32'(stage_idx), 0);
    checkOutput({name, ".startTotal"}, 32'(total_cycles), 0);

    while (busy && iter < 200) begin
      stage_finish = '0;
      abort        = 1'b0;
      start        = 1'b0;
      if (stage_en[0]) begin
        c0++;
        if (c0 == fin0) stage_finish[0] = 1'b1;
        if (stray) stage_finish[1] = 1'b1;
        if (restart && c0 == 2) start = 1'b1;
      end
      if (stage_en[1]) begin
        c1++;
        if (c1 == fin1) stage_finish[1] = 1'b1;
        if (c1 == abortAt1) begin
          abort           = 1'b1;
          stage_finish[1] = 1'b1;
        end
      end
      @(posedge clk); #1;
      iter++;
    end
    stage_finish = '0;
    abort        = 1'b0;
    start        = 1'b0;
    if (iter >= 200) checkOutput({name, ".runBound"}, 32'(iter), 0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput({name, ".heldTotal"}, 32'(total_cycles), 32'(eTotal));
    checkOutput({name, ".idleEn"}, 32'(stage_en), 0);
    checkOutput({name, ".idleBusy"}, 32'(busy), 0);
    checkOutput({name, ".idleErr"}, 32'(error), 32'(eErr));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: simulation did not finish");
    $fatal(1, "[TB] global time limit reached");
  end

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; stage_finish = '0;
    #12;
    checkOutput("rstEn", 32'(stage_en), 0);
    checkOutput("rstBusy", 32'(busy), 0);
    checkOutput("rstDone", 32'(done), 0);
    checkOutput("rstErr", 32'(error), 0);
    checkOutput("rstTotal", 32'(total_cycles), 0);
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;

    //             name       f0 f1 ab st rs kind     e0 e1 gp tot es er
    applyStimulus("basic",    5, 3, 0, 0, 0, K_DONE,  5, 3, 1,  9, 0, 0);
    applyStimulus("timeout",  4, 0, 0, 0, 0, K_ERR,   4, 8, 1, 13, 1, 1);
    applyStimulus("fromErr",  2, 2, 0, 0, 0, K_DONE,  2, 2, 1,  5, 0, 0);
    applyStimulus("finVsTo",  8, 1, 0, 0, 0, K_DONE,  8, 1, 1, 10, 0, 0);
    applyStimulus("abort",    3, 0, 3, 0, 0, K_ABORT, 3, 3, 1,  7, 0, 0);
    applyStimulus("stray",    6, 2, 0, 1, 1, K_DONE,  6, 2, 1,  9, 0, 0);
    applyStimulus("timeout2", 1, 0, 0, 0, 0, K_ERR,   1, 8, 1, 10, 1, 1);

    // Mid-run asynchronous reset while stage 1 is running, after an error left err_stage=1.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    stage_finish = 2'b01;
    @(posedge clk); #1;
    stage_finish = '0;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("preRstIdx", 32'(stage_idx), 1);
    checkOutput("preRstErrStage", 32'(err_stage), 1);
    rst = 1'b0;
    #1;
    checkOutput("asyncEn", 32'(stage_en), 0);
    checkOutput("asyncIdx", 32'(stage_idx), 0);
    checkOutput("asyncBusy", 32'(busy), 0);
    checkOutput("asyncDone", 32'(done), 0);
    checkOutput("asyncErr", 32'(error), 0);
    checkOutput("asyncErrStage", 32'(err_stage), 0);
    checkOutput("asyncTotal", 32'(total_cycles), 0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("postRstBusy", 32'(busy), 0);
    checkOutput("queueEmpty", 32'(expQ.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
